// File: rtl/data_mem_port_if.sv
// Backing data-memory bus: word-addressed request/acknowledge handshake.
// master = the MEM-stage responder, slave = the data memory.
interface data_mem_port_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/data_mem_port.sv
// MEM-stage data-memory responder for the RV32I pipeline.
// Turns a load/store into one request/ack transaction on the data memory,
// lane-aligns store data/strobes, extends load data and stalls the pipe
// while the transaction is outstanding.
// Optional feature: define MISALIGN_CHECK_EN to trap misaligned LH/LHU/SH/LW/SW
// accesses (no memory access, one-cycle misalign_err, rdata cleared).
module data_mem_port #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cache_read_en,
  input  logic [3:0]            cache_write_en,
  input  logic [2:0]            load_type,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic                  misalign_err,
  data_mem_port_if.master       mem
);

  // Load-type codes shared with the decoder.
  localparam logic [2:0] LB         = 3'b000;
  localparam logic [2:0] LH         = 3'b001;
  localparam logic [2:0] LW         = 3'b010;
  localparam logic [2:0] LBU        = 3'b100;
  localparam logic [2:0] LHU        = 3'b101;
  localparam logic [2:0] NOREGWRITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  req;
  logic                  is_write;
  logic                  misaligned;

  // Transaction captured in IDLE, held stable for the whole REQ phase.
  logic                  we_p1;
  logic [ADDR_WIDTH-3:0] addr_p1;
  logic [1:0]            off_p1;
  logic [2:0]            ltype_p1;
  logic [3:0]            wstrb_p1;
  logic [31:0]           wdata_p1;

  // Shift the addressed lane down to bit 0, then extend by load type.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ltype);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (ltype)
      LB:      extend_load = {{24{sh[7]}}, sh[7:0]};
      LBU:     extend_load = {24'd0, sh[7:0]};
      LH:      extend_load = {{16{sh[15]}}, sh[15:0]};
      LHU:     extend_load = {16'd0, sh[15:0]};
      LW:      extend_load = sh;
      default: extend_load = 32'd0;
    endcase
  endfunction

  assign is_write = |cache_write_en;
  assign req      = cache_read_en | is_write;

`ifdef MISALIGN_CHECK_EN
  // Flag halfword accesses on odd bytes and word accesses off a word boundary.
  always_comb begin
    misaligned = 1'b0;
    if (is_write) begin
      if (cache_write_en == 4'b0011 && addr[0])
        misaligned = 1'b1;
      else if (cache_write_en == 4'b1111 && addr[1:0] != 2'b00)
        misaligned = 1'b1;
    end else begin
      case (load_type)
        LH, LHU: misaligned = addr[0];
        LW:      misaligned = (addr[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  // One-cycle error pulse, visible in the DONE cycle of a trapped access.
  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else
      misalign_err <= (state_q == IDLE) && req && misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state, pipeline stall and memory-bus outputs.
  always_comb begin
    state_d        = state_q;
    stall          = req && (state_q != DONE);
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = addr_p1;
    mem.mem_wstrb  = 4'd0;
    mem.mem_wdata  = 32'd0;
    case (state_q)
      IDLE: begin
        if (req)
          state_d = misaligned ? DONE : REQ;
      end
      REQ: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_p1;
        mem.mem_wstrb = wstrb_p1;
        mem.mem_wdata = wdata_p1;
        if (mem.mem_ack)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the request in IDLE; update the load result on a read ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      off_p1   <= 2'd0;
      ltype_p1 <= NOREGWRITE;
      wstrb_p1 <= 4'd0;
      wdata_p1 <= 32'd0;
      rdata    <= 32'd0;
    end else begin
      if (state_q == IDLE && req) begin
        we_p1    <= is_write;
        addr_p1  <= addr[ADDR_WIDTH-1:2];
        off_p1   <= addr[1:0];
        ltype_p1 <= load_type;
        wstrb_p1 <= cache_write_en << addr[1:0];
        wdata_p1 <= wdata << {addr[1:0], 3'b000};
        if (misaligned)
          rdata <= 32'd0;
      end
      if (state_q == REQ && mem.mem_ack && !we_p1)
        rdata <= extend_load(mem.mem_rdata, off_p1, ltype_p1);
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: stores, loads with every extension,
// write-over-read priority, reset mid-transaction and misaligned word load.
module tb_data_mem_port;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cache_read_en;
  logic [3:0]  cache_write_en;
  logic [2:0]  load_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;

  data_mem_port_if #(.ADDR_WIDTH(32)) mem_if ();

  data_mem_port #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cache_read_en  (cache_read_en),
    .cache_write_en (cache_write_en),
    .load_type      (load_type),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .stall          (stall),
    .misalign_err   (misalign_err),
    .mem            (mem_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_txn.
  int          stall_cnt;
  int          req_cycles;
  logic        saw_req;
  logic        done_seen;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_wdata;
  logic [31:0] done_rdata;
  logic        done_err;
  logic        post_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, answer it ack_dly REQ cycles late with rword,
  // and record what the bus and pipeline-side outputs did.
  task automatic run_txn(input logic rd, input logic [3:0] we, input logic [2:0] lt,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_dly, input logic [31:0] rword);
    @(negedge clk);
    cache_read_en  = rd;
    cache_write_en = we;
    load_type      = lt;
    addr           = a;
    wdata          = wd;
    stall_cnt  = 0;
    req_cycles = 0;
    saw_req    = 1'b0;
    done_seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (mem_if.mem_req) begin
        if (!saw_req) begin
          saw_req   = 1'b1;
          cap_we    = mem_if.mem_we;
          cap_addr  = 32'(mem_if.mem_addr);
          cap_wstrb = mem_if.mem_wstrb;
          cap_wdata = mem_if.mem_wdata;
        end
        mem_if.mem_rdata = rword;
        mem_if.mem_ack   = (req_cycles == ack_dly);
        req_cycles++;
      end else begin
        mem_if.mem_ack = 1'b0;
      end
      if (!stall) begin
        done_seen  = 1'b1;
        done_rdata = rdata;
        done_err   = misalign_err;
        break;
      end
      @(negedge clk);
    end
    check("txn_completed", 32'(done_seen), 32'd1);
    cache_read_en  = 1'b0;
    cache_write_en = 4'd0;
    @(negedge clk);
    #1;
    post_err = misalign_err;
  endtask

  initial begin
    rst_n           = 1'b0;
    cache_read_en   = 1'b0;
    cache_write_en  = 4'd0;
    load_type       = LW;
    addr            = 32'd0;
    wdata           = 32'd0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'd0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_rdata",     rdata,                      32'd0);
    check("rst_mem_req",   32'(mem_if.mem_req),        32'd0);
    check("rst_mem_we",    32'(mem_if.mem_we),         32'd0);
    check("rst_mem_addr",  32'(mem_if.mem_addr),       32'd0);
    check("rst_mem_wstrb", 32'(mem_if.mem_wstrb),      32'd0);
    check("rst_mem_wdata", mem_if.mem_wdata,           32'd0);
    check("rst_err",       32'(misalign_err),          32'd0);
    check("rst_stall",     32'(stall),                 32'd0);
    rst_n = 1'b1;

    // SW 0x100, ack in the second REQ cycle.
    run_txn(1'b0, 4'b1111, LW, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    check("sw_we",        32'(cap_we),  32'd1);
    check("sw_addr",      cap_addr,     32'h40);
    check("sw_wstrb",     32'(cap_wstrb), 32'hF);
    check("sw_wdata",     cap_wdata,    32'hDEADBEEF);
    check("sw_stall_cyc", 32'(stall_cnt), 32'd3);
    check("sw_req_cyc",   32'(req_cycles), 32'd2);
    check("sw_rdata",     done_rdata,   32'd0);
    check("idle_wstrb",   32'(mem_if.mem_wstrb), 32'd0);
    check("idle_req",     32'(mem_if.mem_req),   32'd0);

    // SB 0x103, ack in the first REQ cycle (minimum occupancy).
    run_txn(1'b0, 4'b0001, LB, 32'h103, 32'h000000A5, 0, 32'h0);
    check("sb_addr",      cap_addr,       32'h40);
    check("sb_wstrb",     32'(cap_wstrb), 32'h8);
    check("sb_wdata",     cap_wdata,      32'hA5000000);
    check("sb_stall_cyc", 32'(stall_cnt), 32'd2);

    // Loads from 0x202 of word 0x80FF7F01: upper half 0x80FF.
    run_txn(1'b1, 4'd0, LB, 32'h202, 32'h0, 0, 32'h80FF7F01);
    check("lb_we",    32'(cap_we), 32'd0);
    check("lb_addr",  cap_addr,    32'h80);
    check("lb_rdata", done_rdata,  32'hFFFFFFFF);
    run_txn(1'b1, 4'd0, LBU, 32'h202, 32'h0, 2, 32'h80FF7F01);
    check("lbu_rdata", done_rdata, 32'h000000FF);
    run_txn(1'b1, 4'd0, LH, 32'h202, 32'h0, 0, 32'h80FF7F01);
    check("lh_rdata", done_rdata,  32'hFFFF80FF);
    run_txn(1'b1, 4'd0, LHU, 32'h202, 32'h0, 1, 32'h80FF7F01);
    check("lhu_rdata", done_rdata, 32'h000080FF);
    run_txn(1'b1, 4'd0, LW, 32'h200, 32'h0, 0, 32'h80FF7F01);
    check("lw_rdata", done_rdata,  32'h80FF7F01);
    run_txn(1'b1, 4'd0, LB, 32'h201, 32'h0, 0, 32'h80FF7F01);
    check("lb_pos_rdata", done_rdata, 32'h0000007F);

    // Read and write together: write wins, rdata keeps the previous load.
    run_txn(1'b1, 4'b0011, LW, 32'h10, 32'h12345678, 0, 32'hCAFEF00D);
    check("ww_we",    32'(cap_we),    32'd1);
    check("ww_wstrb", 32'(cap_wstrb), 32'h3);
    check("ww_rdata", done_rdata,     32'h0000007F);

    // Reset while waiting for ack; the ack arriving then and afterwards is dropped.
    @(negedge clk);
    cache_read_en = 1'b1;
    load_type     = LW;
    addr          = 32'h200;
    @(negedge clk);
    #1;
    check("rst_mid_pre_req", 32'(mem_if.mem_req), 32'd1);
    rst_n            = 1'b0;
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    check("rst_mid_req",   32'(mem_if.mem_req), 32'd0);
    check("rst_mid_rdata", rdata,               32'd0);
    rst_n         = 1'b1;
    cache_read_en = 1'b0;
    @(negedge clk);
    #1;
    check("late_ack_req",   32'(mem_if.mem_req), 32'd0);
    check("late_ack_rdata", rdata,               32'd0);
    check("late_ack_stall", 32'(stall),          32'd0);
    mem_if.mem_ack = 1'b0;

    // Misaligned LW at 0x101.
    run_txn(1'b1, 4'd0, LW, 32'h101, 32'h0, 0, 32'h11223344);
`ifdef MISALIGN_CHECK_EN
    check("mis_no_req",  32'(saw_req),  32'd0);
    check("mis_err",     32'(done_err), 32'd1);
    check("mis_err_end", 32'(post_err), 32'd0);
    check("mis_rdata",   done_rdata,    32'd0);
`else
    check("mis_req",   32'(saw_req),  32'd1);
    check("mis_addr",  cap_addr,      32'h40);
    check("mis_err",   32'(done_err), 32'd0);
    check("mis_rdata", done_rdata,    32'h00112233);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

MEM-stage data-memory responder for the RV32I 5-stage pipeline: the consuming end of the decoder's `cache_read_en`, `cache_write_en` and `load_type` control fields. It turns a load or store into a word-aligned request/acknowledge transaction on the backing data memory. It aligns store bytes and strobes to the addressed lanes, and extracts and sign- or zero-extends load data. While a transaction is outstanding it stalls the pipeline.

## Interface
- `ADDR_WIDTH`, 32: byte address width; `mem_addr` carries bits [ADDR_WIDTH-1:2].
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cache_read_en` in 1: load request from the MEM stage.
- `cache_write_en` in 4: store byte mask relative to lane 0 (0001 SB, 0011 SH, 1111 SW).
- `load_type` in 3: `LB`/`LH`/`LW`/`LBU`/`LHU`/`NOREGWRITE` codes from Parameters.vh.
- `addr` in ADDR_WIDTH: byte address (ALU result).
- `wdata` in 32: store data, lane-0 aligned.
- `rdata` out 32: extended load result, registered.
- `stall` out 1: freezes IF..MEM while high.
- `misalign_err` out 1: one-cycle pulse (only with MISALIGN_CHECK_EN).
- `mem_req` out 1: transaction valid.
- `mem_we` out 1: 1 write, 0 read.
- `mem_addr` out ADDR_WIDTH-2: word address.
- `mem_wstrb` out 4: byte write strobes.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_ack` in 1: transaction complete; read data valid this cycle.
- `mem_rdata` in 32: read word.

## Operation
- Request present: `req = cache_read_en | (|cache_write_en)`. If both a read and a write are present, the write wins; the read is ignored and `rdata` is unchanged.
- FSM states: IDLE, REQ, DONE.
- **IDLE, req=1**
  - Capture `addr`, `load_type` and direction.
  - Capture `mem_wstrb = (cache_write_en << addr[1:0])[3:0]` and `mem_wdata = (wdata << 8*addr[1:0])[31:0]`.
  - Go to REQ.
- **IDLE, req=0:** stay in IDLE.
- **REQ**
  - Hold `mem_req=1` with stable `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` until `mem_ack`.
  - On `mem_ack`:
    - Read: `rdata <= extend(mem_rdata >> 8*off, type)`, where `off` is the captured `addr[1:0]`.
    - Write: `rdata` is unchanged.
    - Go to DONE.
- **DONE:** unconditionally go to IDLE. The pipeline advances this cycle, so the next MEM instruction is sampled in IDLE.
- Extension rules:
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: full word.
  - Any other code: 0.
- `stall = req & (state != DONE)`. It is combinational and asserts in the same cycle a request appears in IDLE.
- Bytes shifted past lane 3 are dropped.
- Outputs outside REQ: `mem_req=0`; `mem_we`, `mem_wstrb` and `mem_wdata` are driven 0.

## Timing
- Reset values: state IDLE, `rdata=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wstrb=0`, `mem_wdata=0`, `misalign_err=0`.
- `stall` follows `req` combinationally.
- Latency:
  - Request seen in cycle 0 (stall=1).
  - `mem_req` high from cycle 1.
  - With ack in cycle k≥1, DONE is in cycle k+1, where `stall=0` and `rdata` is valid.
  - Minimum occupancy is 3 cycles.
- `mem_ack` is ignored outside REQ.
- `mem_ack` in the first REQ cycle is legal.
- Reset mid-transaction: the next cycle is IDLE with `mem_req=0`; a pending ack is discarded.
- Back-to-back requests: DONE→IDLE→REQ, with one IDLE bubble cycle (stall high) between transactions.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - The check runs in IDLE on a request. The transaction is misaligned if it is LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`.
  - A misaligned transaction does not enter REQ and issues no memory access.
  - The FSM goes directly to DONE, with `misalign_err=1` and `rdata=0` in that DONE cycle.
- `MISALIGN_CHECK_EN` undefined:
  - No check is performed; the lane-truncation rules apply.
  - `misalign_err` is tied to 0.

## Test plan
- SW `addr=0x100`, `wdata=0xDEADBEEF`, ack after 2 cycles:
  - `mem_addr=0x40`, `mem_wstrb=1111`, `mem_wdata=0xDEADBEEF`.
  - `stall` high for 3 cycles, low in DONE.
- SB `addr=0x103`, `wdata=0x000000A5`, ack in the first REQ cycle: `mem_wstrb=1000`, `mem_wdata=0xA5000000`.
- `mem_rdata=0x80FF7F01` at `addr=0x202`:
  - LB gives `rdata=0xFFFFFFFF`.
  - LBU gives `0x000000FF`.
  - LH gives `0xFFFF80FF`.
  - LHU gives `0x000080FF`.
- `rst_n=0` while in REQ awaiting ack: next cycle `mem_req=0`, `rdata=0`, state IDLE; a late ack produces no update.
- Misalignment on LW `addr=0x101`:
  - With `MISALIGN_CHECK_EN`: no `mem_req`, `misalign_err` pulses one cycle, `rdata=0`.
  - Without it: `mem_addr=0x40` is issued and `rdata = mem_rdata >> 8`.
